// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin grant with burst/lock protection,
// address/control mux from the address-phase owner, HWDATA mux from the data-phase owner.
module ahb_bus_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HREADY,
   input  logic [1:0]        HBUSREQ,
   input  logic [1:0]        HLOCK,
   input  logic [1:0]        HTRANS_M0,
   input  logic [1:0]        HTRANS_M1,
   input  logic [ADDR_W-1:0] HADDR_M0,
   input  logic [ADDR_W-1:0] HADDR_M1,
   input  logic              HWRITE_M0,
   input  logic              HWRITE_M1,
   input  logic [2:0]        HSIZE_M0,
   input  logic [2:0]        HSIZE_M1,
   input  logic [2:0]        HBURST_M0,
   input  logic [2:0]        HBURST_M1,
   input  logic [3:0]        HPROT_M0,
   input  logic [3:0]        HPROT_M1,
   input  logic [DATA_W-1:0] HWDATA_M0,
   input  logic [DATA_W-1:0] HWDATA_M1,
   output logic [1:0]        HGRANT,
   output logic              HMASTER,
   output logic [1:0]        HTRANS,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic              HMASTLOCK,
   output logic [DATA_W-1:0] HWDATA
);

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransBusy   = 2'b01;
   localparam logic [1:0] TransNonseq = 2'b10;
   localparam logic [1:0] TransSeq    = 2'b11;

   localparam logic [2:0] BurstSingle = 3'b000;
   localparam logic [2:0] BurstIncr   = 3'b001;

   typedef enum logic [0:0] {OwnM0, OwnM1} owner_e;

   owner_e      owner_q, owner_d;
   logic        data_owner_q;
   logic [3:0]  beat_cnt_q, beat_cnt_d;
   logic        incr_q, incr_d;
   logic [3:0]  burst_len_m1;
   logic        handover;

   assign HMASTER = (owner_q == OwnM1);
   assign HGRANT  = (owner_q == OwnM1) ? 2'b10 : 2'b01;

   // Address/control mux follows the address-phase owner
   always_comb begin
      HTRANS    = HTRANS_M0;
      HADDR     = HADDR_M0;
      HWRITE    = HWRITE_M0;
      HSIZE     = HSIZE_M0;
      HBURST    = HBURST_M0;
      HPROT     = HPROT_M0;
      HMASTLOCK = HLOCK[0];
      if (owner_q == OwnM1) begin
         HTRANS    = HTRANS_M1;
         HADDR     = HADDR_M1;
         HWRITE    = HWRITE_M1;
         HSIZE     = HSIZE_M1;
         HBURST    = HBURST_M1;
         HPROT     = HPROT_M1;
         HMASTLOCK = HLOCK[1];
      end
   end

   assign HWDATA = data_owner_q ? HWDATA_M1 : HWDATA_M0;

   always_comb begin
      burst_len_m1 = 4'd0;
      case (HBURST)
         3'b010, 3'b011: burst_len_m1 = 4'd3;
         3'b100, 3'b101: burst_len_m1 = 4'd7;
         3'b110, 3'b111: burst_len_m1 = 4'd15;
         default:        burst_len_m1 = 4'd0;
      endcase
   end

   // An undefined-length INCR owner may be pre-empted once it drops its request
   always_comb begin
      handover = 1'b0;
      if (HREADY && !HMASTLOCK) begin
         if (HTRANS == TransIdle) handover = 1'b1;
         if (HTRANS == TransNonseq && HBURST == BurstSingle) handover = 1'b1;
         if (HTRANS == TransSeq && beat_cnt_q == 4'd1) handover = 1'b1;
         if (!HBUSREQ[HMASTER] && incr_q) handover = 1'b1;
      end
   end

   always_comb begin
      owner_d = owner_q;
      if (handover) begin
         unique case (HBUSREQ)
            2'b11:   owner_d = (owner_q == OwnM0) ? OwnM1 : OwnM0;
            2'b10:   owner_d = OwnM1;
            2'b01:   owner_d = OwnM0;
            default: owner_d = OwnM0;
         endcase
      end
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      incr_d     = incr_q;
      if (HREADY) begin
         unique case (HTRANS)
            TransIdle:   incr_d = 1'b0;
            TransBusy:   ;
            TransNonseq: begin
               beat_cnt_d = burst_len_m1;
               incr_d     = (HBURST == BurstIncr);
            end
            TransSeq:    beat_cnt_d = (beat_cnt_q == 4'd0) ? 4'd0 : beat_cnt_q - 4'd1;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         owner_q      <= OwnM0;
         data_owner_q <= 1'b0;
         beat_cnt_q   <= 4'd0;
         incr_q       <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         incr_q     <= incr_d;
         if (HREADY) data_owner_q <= HMASTER;
      end
   end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter: reset, round-robin, burst
// protection, wait states, lock and asynchronous reset mid-burst.
module tb_ahb_bus_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   localparam logic [DW-1:0] D_M0 = 64'hA5A5_A5A5_A5A5_A5A5;
   localparam logic [DW-1:0] D_M1 = 64'h5A5A_5A5A_5A5A_5A5A;

   logic          HCLK = 1'b0;
   logic          HRESET, HREADY;
   logic [1:0]    HBUSREQ, HLOCK, HTRANS_M0, HTRANS_M1;
   logic [AW-1:0] HADDR_M0, HADDR_M1;
   logic          HWRITE_M0, HWRITE_M1;
   logic [2:0]    HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1;
   logic [3:0]    HPROT_M0, HPROT_M1;
   logic [DW-1:0] HWDATA_M0, HWDATA_M1;
   logic [1:0]    HGRANT, HTRANS;
   logic          HMASTER, HWRITE, HMASTLOCK;
   logic [AW-1:0] HADDR;
   logic [2:0]    HSIZE, HBURST;
   logic [3:0]    HPROT;
   logic [DW-1:0] HWDATA;

   int checks = 0;
   int errors = 0;

   always #5 HCLK = ~HCLK;

   ahb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HREADY(HREADY), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
      .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1), .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
      .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1), .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
      .HBURST_M0(HBURST_M0), .HBURST_M1(HBURST_M1), .HPROT_M0(HPROT_M0), .HPROT_M1(HPROT_M1),
      .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1), .HGRANT(HGRANT), .HMASTER(HMASTER),
      .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA)
   );

   // Inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      tick();
      HBURST_M0 = 3'b011; HBURST_M1 = 3'b101;
      HPROT_M0 = 4'h3;    HPROT_M1 = 4'hC;
      HSIZE_M0 = 3'd3;    HSIZE_M1 = 3'd2;
      #2 HRESET = 1'b0;
      #1;
      checks++;
      if (HGRANT !== 2'b01) begin
         errors++; $display("FAIL reset_hgrant: got %b expected 01", HGRANT);
      end
      checks++;
      if (HMASTER !== 1'b0) begin
         errors++; $display("FAIL reset_hmaster: got %b expected 0", HMASTER);
      end
      checks++;
      if (HWDATA !== D_M0) begin
         errors++; $display("FAIL reset_hwdata: got %h expected %h", HWDATA, D_M0);
      end
      checks++;
      if (dut.beat_cnt_q !== 4'd0) begin
         errors++; $display("FAIL reset_count: got %0d expected 0", dut.beat_cnt_q);
      end
      #1 HRESET = 1'b1;
      HTRANS_M0 = NONSEQ; HTRANS_M1 = SEQ; HADDR_M0 = 32'h40; HADDR_M1 = 32'h80;
      HBURST_M0 = 3'b000;
      #1;
      checks++;
      if (HTRANS !== NONSEQ || HADDR !== 32'h40) begin
         errors++; $display("FAIL reset_follow_m0: got %b/%h expected 10/00000040", HTRANS, HADDR);
      end
      checks++;
      if (HBURST !== 3'b000 || HPROT !== 4'h3 || HSIZE !== 3'd3) begin
         errors++;
         $display("FAIL reset_ctrl_m0: got %b/%h/%0d expected 000/3/3", HBURST, HPROT, HSIZE);
      end
      tick();
      checks++;
      if (HGRANT !== 2'b01) begin
         errors++; $display("FAIL reset_park: got %b expected 01", HGRANT);
      end
      HTRANS_M0 = IDLE; HTRANS_M1 = IDLE;
   endtask

   task automatic test_round_robin();
      logic exp_owner;
      HBUSREQ = 2'b11;
      HTRANS_M0 = NONSEQ; HTRANS_M1 = NONSEQ;
      HBURST_M0 = 3'b000; HBURST_M1 = 3'b000;
      HWRITE_M0 = 1'b1;   HWRITE_M1 = 1'b1;
      HADDR_M0 = 32'h200; HADDR_M1 = 32'h300;
      exp_owner = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (HMASTER !== exp_owner || HADDR !== (exp_owner ? 32'h300 : 32'h200)) begin
            errors++;
            $display("FAIL rr_owner[%0d]: got %b/%h expected %b", i, HMASTER, HADDR, exp_owner);
         end
         if (i > 0) begin
            checks++;
            if (HWDATA !== (exp_owner ? D_M0 : D_M1)) begin
               errors++;
               $display("FAIL rr_hwdata[%0d]: got %h expected %h", i, HWDATA,
                        exp_owner ? D_M0 : D_M1);
            end
         end
         tick();
         exp_owner = ~exp_owner;
      end
      HBUSREQ = 2'b00; HTRANS_M0 = IDLE; HTRANS_M1 = IDLE;
      tick();
   endtask

   task automatic test_burst_protection();
      HBUSREQ = 2'b11;
      HBURST_M0 = 3'b011;
      HTRANS_M1 = NONSEQ; HBURST_M1 = 3'b000; HADDR_M1 = 32'h300;
      for (int b = 0; b < 4; b++) begin
         HTRANS_M0 = (b == 0) ? NONSEQ : SEQ;
         HADDR_M0  = 32'h10 + 32'(4 * b);
         #1;
         checks++;
         if (HMASTER !== 1'b0 || HADDR !== 32'h10 + 32'(4 * b)) begin
            errors++;
            $display("FAIL burst_hold[%0d]: got %b/%h expected 0/%h", b, HMASTER, HADDR,
                     32'h10 + 32'(4 * b));
         end
         tick();
      end
      checks++;
      if (HMASTER !== 1'b1 || HGRANT !== 2'b10) begin
         errors++; $display("FAIL burst_handover: got %b/%b expected 1/10", HMASTER, HGRANT);
      end
      checks++;
      if (HWDATA !== D_M0) begin
         errors++; $display("FAIL burst_last_data: got %h expected %h", HWDATA, D_M0);
      end
   endtask

   task automatic test_wait_states();
      HBUSREQ = 2'b11;
      HTRANS_M0 = NONSEQ; HBURST_M0 = 3'b000;
      HBURST_M1 = 3'b100;
      for (int b = 0; b < 8; b++) begin
         HTRANS_M1 = (b == 0) ? NONSEQ : SEQ;
         HADDR_M1  = 32'h400 + 32'(4 * b);
         if (b == 1) begin
            HREADY = 1'b0;
            for (int w = 0; w < 3; w++) begin
               #1;
               checks++;
               if (HMASTER !== 1'b1 || dut.beat_cnt_q !== 4'd7) begin
                  errors++;
                  $display("FAIL wait_freeze[%0d]: got %b/%0d expected 1/7", w, HMASTER,
                           dut.beat_cnt_q);
               end
               tick();
            end
            HREADY = 1'b1;
         end
         #1;
         checks++;
         if (HMASTER !== 1'b1) begin
            errors++; $display("FAIL wrap8_hold[%0d]: got %b expected 1", b, HMASTER);
         end
         tick();
      end
      checks++;
      if (HMASTER !== 1'b0) begin
         errors++; $display("FAIL wrap8_handover: got %b expected 0", HMASTER);
      end
   endtask

   task automatic test_lock();
      HBUSREQ = 2'b11; HLOCK = 2'b01;
      HTRANS_M0 = NONSEQ; HBURST_M0 = 3'b000;
      HTRANS_M1 = NONSEQ; HBURST_M1 = 3'b000;
      for (int i = 0; i < 3; i++) begin
         HADDR_M0 = 32'h600 + 32'(4 * i);
         #1;
         checks++;
         if (HMASTLOCK !== 1'b1 || HMASTER !== 1'b0) begin
            errors++;
            $display("FAIL lock_hold[%0d]: got lock %b owner %b expected 1/0", i, HMASTLOCK,
                     HMASTER);
         end
         tick();
      end
      HLOCK = 2'b00; HTRANS_M0 = IDLE; HBUSREQ = 2'b10;
      #1;
      checks++;
      if (HMASTLOCK !== 1'b0 || HMASTER !== 1'b0) begin
         errors++;
         $display("FAIL lock_release: got lock %b owner %b expected 0/0", HMASTLOCK, HMASTER);
      end
      tick();
      checks++;
      if (HMASTER !== 1'b1 || HGRANT !== 2'b10) begin
         errors++; $display("FAIL lock_handover: got %b/%b expected 1/10", HMASTER, HGRANT);
      end
   endtask

   task automatic test_async_reset();
      HBUSREQ = 2'b11; HBURST_M1 = 3'b101;
      for (int b = 0; b < 4; b++) begin
         HTRANS_M1 = (b == 0) ? NONSEQ : SEQ;
         HADDR_M1  = 32'h700 + 32'(4 * b);
         #1;
         checks++;
         if (HMASTER !== 1'b1) begin
            errors++; $display("FAIL incr8_hold[%0d]: got %b expected 1", b, HMASTER);
         end
         tick();
      end
      HTRANS_M1 = SEQ; HADDR_M1 = 32'h710;
      #1;
      checks++;
      if (dut.beat_cnt_q !== 4'd4) begin
         errors++; $display("FAIL incr8_count: got %0d expected 4", dut.beat_cnt_q);
      end
      #1 HRESET = 1'b0;
      #1;
      checks++;
      if (HGRANT !== 2'b01 || HMASTER !== 1'b0 || dut.beat_cnt_q !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: got %b/%b/%0d expected 01/0/0", HGRANT, HMASTER,
                  dut.beat_cnt_q);
      end
      #1 HRESET = 1'b1;
      HBUSREQ = 2'b01; HTRANS_M1 = IDLE;
      HTRANS_M0 = NONSEQ; HBURST_M0 = 3'b000; HADDR_M0 = 32'h500; HWRITE_M0 = 1'b0;
      #1;
      checks++;
      if (HTRANS !== NONSEQ || HADDR !== 32'h500 || HWRITE !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_nonseq: got %b/%h/%b expected 10/00000500/0", HTRANS, HADDR,
                  HWRITE);
      end
      tick();
      checks++;
      if (HMASTER !== 1'b0) begin
         errors++; $display("FAIL post_reset_owner: got %b expected 0", HMASTER);
      end
   endtask

   initial begin
      HRESET = 1'b0; HREADY = 1'b1; HBUSREQ = 2'b00; HLOCK = 2'b00;
      HTRANS_M0 = IDLE; HTRANS_M1 = IDLE; HADDR_M0 = '0; HADDR_M1 = '0;
      HWRITE_M0 = 1'b0; HWRITE_M1 = 1'b0; HSIZE_M0 = 3'd3; HSIZE_M1 = 3'd3;
      HBURST_M0 = 3'b000; HBURST_M1 = 3'b000; HPROT_M0 = 4'h3; HPROT_M1 = 4'h3;
      HWDATA_M0 = D_M0; HWDATA_M1 = D_M1;
      #12 HRESET = 1'b1;
      test_reset();
      test_round_robin();
      test_burst_protection();
      test_wait_states();
      test_lock();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Two-master AHB-Lite arbiter and address/write-data multiplexer for the Triple DES SoC bus. It shares the single slave-side AHB-Lite bus (DES core slave, DefaultSlave) between master 0 (host/test master) and master 1 (key/data DMA master). It uses round-robin grant with burst and HMASTLOCK protection. It drives the shared address/control bus from the address-phase owner and HWDATA from the data-phase owner.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, HWDATA width

Ports:
HCLK  in  1  bus clock
HRESET  in  1  asynchronous reset, active-low
HREADY  in  1  shared transfer-done from slave mux
HBUSREQ  in  2  bus request, bit i = master i
HLOCK  in  2  lock request, bit i = master i
HTRANS_M0, HTRANS_M1  in  2  master transfer type
HADDR_M0, HADDR_M1  in  ADDR_W  master address
HWRITE_M0, HWRITE_M1  in  1  master write flag
HSIZE_M0, HSIZE_M1  in  3  master size
HBURST_M0, HBURST_M1  in  3  master burst type
HPROT_M0, HPROT_M1  in  4  master protection
HWDATA_M0, HWDATA_M1  in  DATA_W  master write data
HGRANT  out  2  one-hot grant (address-phase owner)
HMASTER  out  1  address-phase owner index
HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT  out  as above  muxed address/control to slaves
HMASTLOCK  out  1  HLOCK of current owner
HWDATA  out  DATA_W  write data of data-phase owner

Behaviour:
- Reset (HRESET=0, async): HGRANT=2'b01, HMASTER=0, data-phase owner=0, beat counter=0, last-granted=0. Outputs follow master 0.
- Address mux: outputs are combinational from the owner selected by HMASTER. HMASTLOCK = HLOCK[HMASTER].
- Data-phase owner register: on posedge with HREADY=1, it loads HMASTER. HWDATA = HWDATA_M of the data-phase owner. HREADY=0 holds it.
- Beat counter (4 bits): holds remaining SEQ beats of the owner's fixed-length burst.
  - Updates only on an accepted address phase (HREADY=1).
  - NONSEQ loads len-1. len = 1 for SINGLE, 4 for INCR4/WRAP4, 8 for INCR8/WRAP8, 16 for INCR16/WRAP16. INCR (undefined length) loads 0 and sets an incr flag.
  - SEQ decrements the counter, saturating at 0.
  - BUSY and IDLE leave the counter unchanged; IDLE clears the incr flag.
- Handover point: HREADY=1, HLOCK[HMASTER]=0, and the owner's current transfer is one of:
  - IDLE;
  - NONSEQ with len=1;
  - SEQ with counter==1 (final beat of a fixed burst);
  - any transfer while HBUSREQ[HMASTER]=0 and incr flag set.
- BUSY, mid-burst SEQ/NONSEQ, and any locked cycle are never handover points.
- Arbitration at a handover point, registered on that edge:
  - both request: grant the master other than the current owner (round-robin);
  - one requests: grant it;
  - none request: park on master 0.
- HGRANT/HMASTER change only at handover points and are otherwise held, including throughout HREADY=0 wait states.
- The new owner starts its NONSEQ in the cycle after the grant edge. The previous owner's data phase completes under the registered data-phase owner.
- Lock: a locked owner keeps the bus regardless of other requests until HLOCK drops and a handover point occurs.
- Reset mid-burst: grant returns immediately to master 0 and the counter clears. No pending state survives.

Test Plan:
1. Reset: HRESET=0 mid-cycle, then release with no requests -> HGRANT=01, HMASTER=0, HTRANS follows HTRANS_M0.
2. Round-robin: both HBUSREQ=1, both issue SINGLE NONSEQ writes with HREADY=1 -> grant alternates 0,1,0,1 each transfer. HWDATA lags HADDR by one cycle and comes from the matching master (M0 data 64'hA5A5..., M1 data 64'h5A5A...).
3. Burst protection: M0 INCR4 (NONSEQ + 3 SEQ) at 32'h0000_0010 while M1 requests -> no grant change until the 4th beat is accepted. HMASTER=1 on the next edge.
4. Wait states: M1 issues WRAP8 with HREADY held low 3 cycles on beat 2 -> counter and grant frozen. The burst completes 8 beats before handover.
5. Lock: M0 HLOCK=1 over 3 SINGLE transfers with M1 requesting -> HMASTLOCK=1 and grant stays 0. After HLOCK=0 at the next IDLE, grant goes to 1.
6. Async reset during M1 INCR8 beat 5 -> HGRANT=01 immediately without a clock edge, counter=0. After release, a fresh NONSEQ from M0 is passed to the slave bus.
